// File: rtl/hash_table_ram_pkg.sv
// Shared types for the connection-manager table RAM: ctrl opcodes, FSM states, word-count helper.
package hash_table_ram_pkg;

   typedef enum logic [1:0] {
      CTRL_NOP = 2'b00,
      CTRL_RD  = 2'b01,
      CTRL_WR  = 2'b10,
      CTRL_CLR = 2'b11
   } ctrl_op_e;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_PEND,
      ST_CTRL
   } tbl_state_e;

   localparam int PAR_WORD = 7;

   function automatic int calc_n_word(input int w);
      return (w + 31) / 32;
   endfunction

endpackage

// File: rtl/hash_table_ram_ctrl_if.sv
// Ctrl register front end: INIT sweep, request latch, PEND arbitration, word select/merge.
// With TBL_PARITY_EN defined, word index 7 returns the parity error counter.
module tbl_ctrl_if
   import hash_table_ram_pkg::*;
#(
   parameter int w_entry = 17,
   parameter int d_tb    = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               conf_busy,
   input  logic               ctrl_in_valid,
   input  logic [1:0]         ctrl_opt,
   input  logic [31:0]        ctrl_addr,
   input  logic [31:0]        ctrl_data_in,
   input  logic [w_entry-1:0] ent_rd,
`ifdef TBL_PARITY_EN
   input  logic [15:0]        par_cnt,
`endif
   output logic [d_tb-1:0]    ent_idx,
   output logic               ent_we,
   output logic [w_entry-1:0] ent_wdata,
   output logic               ready,
   output logic               ctrl_out_valid,
   output logic [31:0]        ctrl_data_out
);
   localparam int n_word = calc_n_word(w_entry);

   tbl_state_e state_q, state_d;
   logic [d_tb-1:0] cnt_q, cnt_d;
   logic [1:0]  req_opt_q;
   logic [31:0] req_addr_q, req_data_q;
   logic        latch, svc;
   logic [1:0]  svc_opt;
   logic [31:0] svc_addr, svc_data;
   logic [2:0]  svc_word;
   logic        word_hit;
   logic [32*n_word-1:0] pad_rd, pad_wr;
   logic [31:0] rd_word;
   logic        unused_bits;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      svc     = 1'b0;
      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (ctrl_in_valid && ready) begin
               if (conf_busy) begin
                  latch   = 1'b1;
                  state_d = ST_PEND;
               end else begin
                  svc     = 1'b1;
                  state_d = ST_CTRL;
               end
            end
         end
         ST_PEND: begin
            if (!conf_busy) begin
               svc     = 1'b1;
               state_d = ST_CTRL;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A request serviced straight from IDLE uses the live inputs; from PEND the latched copy.
   assign svc_opt  = (state_q == ST_PEND) ? req_opt_q  : ctrl_opt;
   assign svc_addr = (state_q == ST_PEND) ? req_addr_q : ctrl_addr;
   assign svc_data = (state_q == ST_PEND) ? req_data_q : ctrl_data_in;
   assign svc_word = svc_addr[2:0];

   always_comb begin
      pad_rd = '0;
      pad_rd[w_entry-1:0] = ent_rd;
      pad_wr   = pad_rd;
      rd_word  = '0;
      word_hit = 1'b0;
      for (int k = 0; k < n_word; k++) begin
         if (svc_word == 3'(k)) begin
            rd_word = pad_rd[32*k +: 32];
            pad_wr[32*k +: 32] = svc_data;
            word_hit = 1'b1;
         end
      end
`ifdef TBL_PARITY_EN
      if (svc_word == 3'(PAR_WORD)) rd_word = {16'h0, par_cnt};
`endif
   end

   assign unused_bits = ^{svc_addr[31:d_tb+3], pad_wr};

   always_comb begin
      ent_idx   = (state_q == ST_INIT) ? cnt_q : svc_addr[d_tb+2:3];
      ent_we    = 1'b0;
      ent_wdata = '0;
      if (state_q == ST_INIT) begin
         ent_we = 1'b1;
      end else if (svc) begin
         if (svc_opt == CTRL_WR) begin
            ent_we    = word_hit;
            ent_wdata = pad_wr[w_entry-1:0];
         end else if (svc_opt == CTRL_CLR) begin
            ent_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= ST_INIT;
         cnt_q          <= '0;
         ready          <= 1'b0;
         ctrl_out_valid <= 1'b0;
         ctrl_data_out  <= '0;
         req_opt_q      <= '0;
         req_addr_q     <= '0;
         req_data_q     <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         ready          <= (state_q != ST_INIT);
         ctrl_out_valid <= svc;
         if (svc) ctrl_data_out <= (svc_opt == CTRL_RD) ? rd_word : svc_data;
         if (latch) begin
            req_opt_q  <= ctrl_opt;
            req_addr_q <= ctrl_addr;
            req_data_q <= ctrl_data_in;
         end
      end
   end

endmodule

// File: rtl/hash_table_ram.sv
// Table storage with search/conf ports, write-first forwarding and a ctrl register front end.
// Optional parity protection and par_err output are enabled by defining TBL_PARITY_EN.
module hash_table_ram
   import hash_table_ram_pkg::*;
#(
   parameter int w_entry = 17,
   parameter int d_tb    = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [d_tb-1:0]    idx_search,
   input  logic               rdValid_search,
   output logic [w_entry-1:0] ctx_search,
   input  logic [d_tb-1:0]    idx_conf,
   input  logic               rdValid_conf,
   input  logic               wrValid_conf,
   input  logic [w_entry-1:0] data_conf,
   output logic [w_entry-1:0] ctx_conf,
   output logic               ready,
   input  logic               ctrl_in_valid,
   input  logic [1:0]         ctrl_opt,
   input  logic [31:0]        ctrl_addr,
   input  logic [31:0]        ctrl_data_in,
   output logic               ctrl_out_valid,
   output logic [31:0]        ctrl_data_out
`ifdef TBL_PARITY_EN
   ,
   output logic               par_err
`endif
);
   localparam int depth = 2 ** d_tb;

   logic [w_entry-1:0] mem [depth];
   logic [d_tb-1:0]    ent_idx, wr_idx;
   logic               ent_we, conf_we, wr_en;
   logic [w_entry-1:0] ent_wdata, ent_rd, wr_data;
   logic               fwd_search, fwd_conf;

`ifdef TBL_PARITY_EN
   logic        par_mem [depth];
   logic [15:0] par_err_cnt;
   logic        err_s, err_c;
`endif

   assign conf_we    = wrValid_conf & ready;
   assign fwd_search = conf_we && (idx_conf == idx_search);
   assign fwd_conf   = conf_we;
   assign ent_rd     = mem[ent_idx];

   // INIT and ctrl writes never coincide with a conf write, so one write port suffices.
   assign wr_en   = ent_we | conf_we;
   assign wr_idx  = ent_we ? ent_idx   : idx_conf;
   assign wr_data = ent_we ? ent_wdata : data_conf;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ctx_search <= '0;
         ctx_conf   <= '0;
      end else if (ready) begin
         if (rdValid_search) ctx_search <= fwd_search ? data_conf : mem[idx_search];
         if (rdValid_conf)   ctx_conf   <= fwd_conf   ? data_conf : mem[idx_conf];
      end
   end

`ifdef TBL_PARITY_EN
   always_ff @(posedge clk) begin
      if (wr_en) par_mem[wr_idx] <= ^wr_data;
   end

   assign err_s = ready & rdValid_search & ~fwd_search & (^{mem[idx_search], par_mem[idx_search]});
   assign err_c = ready & rdValid_conf   & ~fwd_conf   & (^{mem[idx_conf],   par_mem[idx_conf]});

   always_ff @(posedge clk) begin
      if (!reset) begin
         par_err     <= 1'b0;
         par_err_cnt <= '0;
      end else begin
         par_err <= err_s | err_c;
         if ((err_s | err_c) && (par_err_cnt != 16'hFFFF)) par_err_cnt <= par_err_cnt + 16'd1;
      end
   end
`endif

   tbl_ctrl_if #(
      .w_entry(w_entry),
      .d_tb   (d_tb)
   ) u_ctrl (
      .clk           (clk),
      .reset         (reset),
      .conf_busy     (rdValid_conf | wrValid_conf),
      .ctrl_in_valid (ctrl_in_valid),
      .ctrl_opt      (ctrl_opt),
      .ctrl_addr     (ctrl_addr),
      .ctrl_data_in  (ctrl_data_in),
      .ent_rd        (ent_rd),
`ifdef TBL_PARITY_EN
      .par_cnt       (par_err_cnt),
`endif
      .ent_idx       (ent_idx),
      .ent_we        (ent_we),
      .ent_wdata     (ent_wdata),
      .ready         (ready),
      .ctrl_out_valid(ctrl_out_valid),
      .ctrl_data_out (ctrl_data_out)
   );

endmodule

// File: tb/tb_hash_table_ram.sv
// Randomized self-checking bench for hash_table_ram (w_entry=17, d_tb=3) against an array model.
module tb_hash_table_ram;
   import hash_table_ram_pkg::*;

   localparam int W     = 17;
   localparam int D     = 3;
   localparam int DEPTH = 8;
   localparam int NW    = 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [D-1:0]  idx_search, idx_conf;
   logic          rdValid_search, rdValid_conf, wrValid_conf;
   logic [W-1:0]  data_conf, ctx_search, ctx_conf;
   logic          ready, ctrl_in_valid, ctrl_out_valid;
   logic [1:0]    ctrl_opt;
   logic [31:0]   ctrl_addr, ctrl_data_in, ctrl_data_out;

   logic [W-1:0]  model [DEPTH];
   logic [W-1:0]  exp_search, exp_conf;
   int            checkCount = 0;
   int            passCount  = 0;

   always #5 clk = ~clk;

   hash_table_ram #(.w_entry(W), .d_tb(D)) dut (
      .clk           (clk),
      .reset         (reset),
      .idx_search    (idx_search),
      .rdValid_search(rdValid_search),
      .ctx_search    (ctx_search),
      .idx_conf      (idx_conf),
      .rdValid_conf  (rdValid_conf),
      .wrValid_conf  (wrValid_conf),
      .data_conf     (data_conf),
      .ctx_conf      (ctx_conf),
      .ready         (ready),
      .ctrl_in_valid (ctrl_in_valid),
      .ctrl_opt      (ctrl_opt),
      .ctrl_addr     (ctrl_addr),
      .ctrl_data_in  (ctrl_data_in),
      .ctrl_out_valid(ctrl_out_valid),
      .ctrl_data_out (ctrl_data_out)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs === exp) passCount++;
      else $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clearModel;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      exp_search = '0;
      exp_conf   = '0;
   endtask

   task automatic applyStimulus(input bit s_en, input int s_idx, input bit c_rd, input bit c_wr,
                                input int c_idx, input logic [W-1:0] c_data);
      rdValid_search = s_en;
      idx_search     = 3'(s_idx);
      rdValid_conf   = c_rd;
      wrValid_conf   = c_wr;
      idx_conf       = 3'(c_idx);
      data_conf      = c_data;
      if (s_en) exp_search = (c_wr && c_idx == s_idx) ? c_data : model[s_idx];
      if (c_rd) exp_conf   = c_wr ? c_data : model[c_idx];
      if (c_wr) model[c_idx] = c_data;
      tick();
      checkOutput("ctx_search", 32'(ctx_search), 32'(exp_search));
      checkOutput("ctx_conf", 32'(ctx_conf), 32'(exp_conf));
   endtask

   task automatic idleCycle;
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 0, '0);
   endtask

   task automatic waitReady;
      for (int i = 1; i <= 8; i++) begin
         tick();
         checkOutput($sformatf("ready_low_c%0d", i), 32'(ready), 32'd0);
      end
      rdValid_search = 1'b0;
      rdValid_conf   = 1'b0;
      wrValid_conf   = 1'b0;
      tick();
      checkOutput("ready_high_c9", 32'(ready), 32'd1);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ctx_search"}, 32'(ctx_search), 32'd0);
      checkOutput({tag, "_ctx_conf"}, 32'(ctx_conf), 32'd0);
      checkOutput({tag, "_ready"}, 32'(ready), 32'd0);
      checkOutput({tag, "_ctrl_out_valid"}, 32'(ctrl_out_valid), 32'd0);
      checkOutput({tag, "_ctrl_data_out"}, ctrl_data_out, 32'd0);
   endtask

   task automatic ctrlRequest(input logic [1:0] opt, input int e, input int w, input logic [31:0] data,
                              input int busy, input bit dup, input bit srch);
      logic [255:0] t;
      logic [31:0]  exp_out;
      int           n;
      bit           got;
      ctrl_in_valid = 1'b1;
      ctrl_opt      = opt;
      ctrl_addr     = 32'((e << 3) | w);
      ctrl_data_in  = data;
      applyStimulus(srch, e, 1'b0, busy > 0, $urandom_range(0, 7), 17'($urandom));
      ctrl_in_valid = 1'b0;
      n   = 1;
      got = ctrl_out_valid;
      while (!got && n < 20) begin
         if (dup && n == 1) begin
            ctrl_in_valid = 1'b1;
            ctrl_opt      = CTRL_WR;
            ctrl_addr     = 32'(((e + 1) % DEPTH) << 3);
            ctrl_data_in  = 32'h0001_5555;
         end
         applyStimulus(1'b0, 0, 1'b0, n < busy, $urandom_range(0, 7), 17'($urandom));
         ctrl_in_valid = 1'b0;
         n++;
         got = ctrl_out_valid;
      end
      checkOutput("ctrl_latency", 32'(n), 32'(1 + busy));
      t = '0;
      t[W-1:0] = model[e];
      exp_out  = data;
      if (opt == CTRL_RD) begin
         exp_out = (w < NW) ? t[32*w +: 32] : 32'd0;
      end else if (opt == CTRL_WR) begin
         if (w < NW) begin
            t[32*w +: 32] = data;
            model[e] = t[W-1:0];
         end
      end else if (opt == CTRL_CLR) begin
         model[e] = '0;
      end
      checkOutput("ctrl_data_out", ctrl_data_out, exp_out);
      idleCycle();
      checkOutput("ctrl_ack_single", 32'(ctrl_out_valid), 32'd0);
   endtask

   initial begin
      reset          = 1'b0;
      idx_search     = '0;
      rdValid_search = 1'b0;
      idx_conf       = '0;
      rdValid_conf   = 1'b0;
      wrValid_conf   = 1'b0;
      data_conf      = '0;
      ctrl_in_valid  = 1'b0;
      ctrl_opt       = '0;
      ctrl_addr      = '0;
      ctrl_data_in   = '0;
      clearModel();

      tick();
      tick();
      checkResetOutputs("reset");
      reset = 1'b1;
      waitReady();

      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, i, 1'b0, 1'b0, 0, '0);

      applyStimulus(1'b0, 0, 1'b0, 1'b1, 5, 17'h1ABCD);
      applyStimulus(1'b1, 5, 1'b0, 1'b0, 0, '0);
      applyStimulus(1'b1, 2, 1'b0, 1'b1, 2, 17'h00F0F);
      applyStimulus(1'b1, 3, 1'b0, 1'b1, 2, 17'h0AAAA);
      applyStimulus(1'b0, 0, 1'b1, 1'b1, 7, 17'h12345);
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 2, '0);
      idleCycle();

      ctrlRequest(CTRL_WR, 4, 0, 32'hFFFF_1234, 0, 1'b0, 1'b1);
      ctrlRequest(CTRL_RD, 4, 0, 32'h0, 0, 1'b0, 1'b0);
      checkOutput("ctrl_rd_e4", ctrl_data_out, 32'h0001_1234);
      applyStimulus(1'b1, 4, 1'b0, 1'b0, 0, '0);
      ctrlRequest(CTRL_RD, 5, 0, 32'h0, 3, 1'b1, 1'b0);
      applyStimulus(1'b1, 6, 1'b0, 1'b0, 0, '0);
      ctrlRequest(CTRL_WR, 4, 1, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
      ctrlRequest(CTRL_RD, 4, 1, 32'h0, 0, 1'b0, 1'b0);
      ctrlRequest(CTRL_RD, 4, 7, 32'h0, 0, 1'b0, 1'b0);
      ctrlRequest(CTRL_CLR, 4, 0, 32'h5A5A_5A5A, 1, 1'b0, 1'b0);
      applyStimulus(1'b1, 4, 1'b0, 1'b0, 0, '0);

      // Reset in the middle of the clear sweep, with strobes held that must be ignored.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      clearModel();
      rdValid_search = 1'b1;
      idx_search     = 3'd5;
      wrValid_conf   = 1'b1;
      idx_conf       = 3'd6;
      data_conf      = 17'h1FFFF;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("init_ctx_search", 32'(ctx_search), 32'd0);
         checkOutput("init_ready", 32'(ready), 32'd0);
      end
      reset = 1'b0;
      tick();
      checkResetOutputs("midinit");
      reset = 1'b1;
      waitReady();
      applyStimulus(1'b1, 6, 1'b0, 1'b0, 0, '0);
      applyStimulus(1'b1, 5, 1'b0, 1'b0, 0, '0);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            int wsel;
            wsel = $urandom_range(0, 3);
            ctrlRequest(2'($urandom_range(0, 3)), $urandom_range(0, 7),
                        (wsel == 3) ? 7 : ((wsel == 2) ? 1 : 0), $urandom,
                        $urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)));
         end else begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 7), 17'($urandom));
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/hash_table_ram.md
Name: hash_table_ram

Overview:
- Storage-side responder for the connection-manager table interfaces: one instance each serves hashTb, flowKTb and connTb.
- Services the search port (read-only) and the conf port (read/write) with fixed 1-cycle read latency and write-first forwarding.
- Also answers the 32-bit ctrl register port for CPU table access.
- Self-clears the table after reset and signals ready when done.

Parameters:
- w_entry, 17, entry width in bits (17 hashTb, 120 flowKTb, 200 connTb); must be ≤256.
- d_tb, 3, index width in bits; table holds 2^d_tb entries.
- n_word, (w_entry+31)/32, 32-bit words per entry (derived localparam).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- idx_search  in  d_tb  search index
- rdValid_search  in  1  search read strobe
- ctx_search  out  w_entry  search read data, 1 cycle after strobe
- idx_conf  in  d_tb  conf index
- rdValid_conf  in  1  conf read strobe
- wrValid_conf  in  1  conf write strobe
- data_conf  in  w_entry  conf write data
- ctx_conf  out  w_entry  conf read data, 1 cycle after strobe
- ready  out  1  table initialised and usable
- ctrl_in_valid  in  1  ctrl request strobe
- ctrl_opt  in  2  01 = read word, 10 = write word, 11 = clear entry, 00 = no-op
- ctrl_addr  in  32  [d_tb+2:3] = entry index, [2:0] = word index
- ctrl_data_in  in  32  ctrl write data
- ctrl_out_valid  out  1  one-cycle ctrl completion pulse
- ctrl_data_out  out  32  ctrl read data (write/clear: echo of ctrl_data_in)

Behaviour:
- Reset (reset=0 at clk edge):
  - All outputs go to 0: ctx_search, ctx_conf, ready, ctrl_out_valid, ctrl_data_out.
  - Any pending ctrl request is dropped.
  - FSM goes to INIT with the clear counter at 0.
  - Reset asserted mid-INIT or mid-ctrl restarts INIT from entry 0.
- FSM states:
  - INIT: writes 0 to entry[cnt] each cycle, cnt+1. After entry 2^d_tb-1, goes to IDLE; ready rises the following cycle and stays 1 until reset. Search/conf strobes in INIT are ignored and ctx outputs hold 0.
  - IDLE: services the ctrl request immediately if the conf port is idle this cycle, otherwise goes to PEND.
  - PEND: waits for a cycle with rdValid_conf=0 and wrValid_conf=0, then services the request.
  - CTRL: one cycle. Read returns word, write/clear commits. Returns to IDLE.
- Search port:
  - ctx_search <= entry[idx_search] registered on the strobe edge; the output holds its value when there is no strobe.
- Conf port:
  - wrValid_conf writes data_conf at the edge.
  - rdValid_conf registers entry[idx_conf] into ctx_conf.
  - Write and read on the same cycle at the same idx: ctx_conf = data_conf (write-first).
- Collisions:
  - Search read same cycle as a conf write to the same idx: ctx_search = data_conf (forwarded).
  - Different idx: no interaction.
- Ctrl read: ctrl_data_out = entry[e][32*w+31:32*w], zero-extended past w_entry; ctrl_out_valid=1 for 1 cycle.
- Ctrl write: read-modify-write of word w only. Bits beyond w_entry are discarded. Word index ≥ n_word is a no-op but still acked.
- Ctrl clear: entry[e] <= 0.
- Ctrl priority:
  - Conf port has priority over ctrl; search never blocks ctrl.
  - A ctrl write commits at the edge, so a search in the same cycle sees the old value.
- ctrl_in_valid while in PEND, or while ready=0, is ignored with no ack. Software must wait for ctrl_out_valid before issuing the next request.
- Latency:
  - Search/conf read: exactly 1 cycle.
  - Ctrl: 1 cycle when conf idle; otherwise 1 + number of busy conf cycles.

Optional Feature:
- TBL_PARITY_EN
  - Defined: each entry stores an extra even-parity bit, computed on every write (conf, ctrl, INIT).
  - Adds output par_err (1 bit, reset 0), which pulses for 1 cycle alongside ctx_search/ctx_conf when the stored parity mismatches.
  - Also adds par_err_cnt (16 bits, saturating), readable via ctrl_addr word index 7.
  - Undefined: no parity storage, no par_err port, word 7 reads 0.

Decomposition:
- Shared package holds:
  - ctrl opcodes CTRL_NOP/RD/WR/CLR
  - FSM state encoding INIT/IDLE/PEND/CTRL
  - function for n_word
- One natural sub-module, tbl_ctrl_if: ctrl request latch, PEND arbitration and word select/merge. The storage array and forwarding stay in the top module.

Test Plan (w_entry=17, d_tb=3):
- Reset release: ready=0 for 8 cycles, rises on cycle 9; every entry then reads 0 via search.
- Conf write idx 5 = 17'h1ABCD, then search idx 5 next cycle -> ctx_search = 17'h1ABCD one cycle after the strobe.
- Same cycle: conf write idx 2 = 17'h00F0F and search idx 2 -> ctx_search = 17'h00F0F (forwarded); search idx 3 in the same cycle returns the old value.
- Ctrl write word 0 of entry 4 = 32'hFFFF_1234 -> entry = 17'h11234, ack after 1 cycle. Ctrl read entry 4 word 0 -> 32'h0001_1234.
- Ctrl read issued while wrValid_conf held for 3 cycles -> ctrl_out_valid exactly 4 cycles after the request; a second ctrl_in_valid during PEND is not acked.
- Assert reset mid-INIT (cnt=4) -> ready stays 0 and the clear restarts, giving ready 9 cycles after release.
